// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the M-extension execution unit
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam int MD_IS_DIV_BIT = 2;

    // {rs1 signed, rs2 signed}, indexed by md_op_e
    localparam logic [1:0] MD_SIGNED [8] = '{
        2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00
    };

endpackage

// File: rtl/md_div_step.sv
// rtl/md_div_step.sv - one combinational restoring-division step
module md_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] div_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    assign trial = {rem_i, bit_i};
    assign diff  = trial - {1'b0, div_i};
    // rem_i < div_i keeps trial below 2*div_i, so the MSB of diff is a clean borrow flag
    assign q_o   = ~diff[XLEN];
    assign rem_o = q_o ? diff[XLEN-1:0] : {rem_i[XLEN-2:0], bit_i};

endmodule

// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - multi-cycle RISC-V M-extension multiply/divide unit
module exe_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1,
    parameter int DIV_BPC = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_v_i,
    output logic            req_rdy_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_adr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            res_v_o,
    input  logic            res_rdy_i,
    output logic [XLEN-1:0] res_data_o,
    output logic [4:0]      res_adr_o
);

    localparam int MIN_BPC = (MUL_BPC < DIV_BPC) ? MUL_BPC : DIV_BPC;
    localparam int CW      = $clog2(XLEN / MIN_BPC) + 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_BPC - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN / DIV_BPC - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_op_e            op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opa_q, opb_q, res_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;

    logic [1:0]      sgn;
    logic            a_neg, b_neg, is_div, is_rem, div_zero, div_ovf, fast, accept, neg_in;
    logic [XLEN-1:0] abs_a, abs_b, fast_res;

    assign sgn      = MD_SIGNED[op_i];
    assign a_neg    = sgn[1] & rs1_data_i[XLEN-1];
    assign b_neg    = sgn[0] & rs2_data_i[XLEN-1];
    assign abs_a    = a_neg ? -rs1_data_i : rs1_data_i;
    assign abs_b    = b_neg ? -rs2_data_i : rs2_data_i;
    assign is_div   = op_i[MD_IS_DIV_BIT];
    assign is_rem   = is_div & op_i[1];
    assign neg_in   = is_rem ? a_neg : (a_neg ^ b_neg);
    assign div_zero = is_div & (rs2_data_i == '0);
    assign div_ovf  = is_div & ~op_i[0] & (rs1_data_i == MOST_NEG) & (&rs2_data_i);
    assign fast     = div_zero | div_ovf;
    assign fast_res = div_zero ? (is_rem ? rs1_data_i : '1) : (is_rem ? '0 : rs1_data_i);
    assign accept   = req_v_i & req_rdy_o & ~flush_i;

    // Right-shifting accumulator: partial products enter at the top half
    logic [XLEN+MUL_BPC-1:0]   mul_pp;
    logic [2*XLEN+MUL_BPC-1:0] mul_sum;
    logic [2*XLEN-1:0]         mul_acc_d, mul_prod;

    always_comb begin
        mul_pp = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (opb_q[j]) mul_pp = mul_pp + ((XLEN+MUL_BPC)'(opa_q) << j);
        end
    end

    assign mul_sum   = {{MUL_BPC{1'b0}}, acc_q} + {mul_pp, {XLEN{1'b0}}};
    assign mul_acc_d = (2*XLEN)'(mul_sum >> MUL_BPC);
    assign mul_prod  = neg_q ? -mul_acc_d : mul_acc_d;

    // Dividend shifts out of opa_q from the top while quotient bits fill from the bottom
    logic [DIV_BPC:0][XLEN-1:0] rem_chain;
    logic [DIV_BPC-1:0]         q_bits;
    logic [XLEN-1:0]            quo_d, div_mag, div_res;

    assign rem_chain[0] = acc_q[XLEN-1:0];

    for (genvar k = 0; k < DIV_BPC; k++) begin : g_div
        md_div_step #(.XLEN(XLEN)) u_step (
            .rem_i (rem_chain[k]),
            .div_i (opb_q),
            .bit_i (opa_q[XLEN-1-k]),
            .rem_o (rem_chain[k+1]),
            .q_o   (q_bits[DIV_BPC-1-k])
        );
    end

    assign quo_d   = (opa_q << DIV_BPC) | XLEN'(q_bits);
    assign div_mag = op_q[1] ? rem_chain[DIV_BPC] : quo_d;
    assign div_res = neg_q ? -div_mag : div_mag;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = fast ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
            ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
            ST_DIV:  if (cnt_q == DIV_LAST) state_d = ST_DONE;
            default: if (res_rdy_i) state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MUL;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q  <= md_op_e'(op_i);
                    rd_q  <= rd_adr_i;
                    opa_q <= abs_a;
                    opb_q <= abs_b;
                    acc_q <= '0;
                    neg_q <= neg_in;
                    cnt_q <= '0;
                    if (fast) res_q <= fast_res;
                end
                ST_MUL: begin
                    acc_q <= mul_acc_d;
                    opb_q <= opb_q >> MUL_BPC;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == MUL_LAST)
                        res_q <= (op_q == MD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                end
                ST_DIV: begin
                    opa_q <= quo_d;
                    acc_q <= {{XLEN{1'b0}}, rem_chain[DIV_BPC]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == DIV_LAST) res_q <= div_res;
                end
                default: ;
            endcase
        end
    end

    assign req_rdy_o  = (state_q == ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign res_v_o    = (state_q == ST_DONE);
    assign res_data_o = res_q;
    assign res_adr_o  = rd_q;

endmodule
